// File: rtl/eth_tx_arbiter_if.sv
// eth_tx_arbiter_if
//   Bundles the source-side request/data signals and the MAC-side output
//   signals of the transmit arbiter.
//   master : the arbiter (takes req/src_active/src_data, drives the rest)
//   slave  : the frame sources / MAC side (mirror of master)
//   Signals:
//     req[3:0]         per-source tx_request (0 ARP, 1 ICMP, 2 DHCP, 3 UDP)
//     src_active[3:0]  per-source tx_active
//     src_data[31:0]   per-source byte, source n on [8n+7:8n]
//     grant[3:0]       per-source tx_enable, one-hot single-cycle pulse
//     tx_data[7:0]     muxed byte to the MAC
//     tx_valid         granted source active while a frame is in flight
//     frame_abort      single-cycle pulse on frame watchdog expiry
//     busy             arbiter is not idle
interface eth_tx_arbiter_if;
    logic [3:0]  req;
    logic [3:0]  src_active;
    logic [31:0] src_data;
    logic [3:0]  grant;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        frame_abort;
    logic        busy;

    modport master (
        input  req, src_active, src_data,
        output grant, tx_data, tx_valid, frame_abort, busy
    );

    modport slave (
        output req, src_active, src_data,
        input  grant, tx_data, tx_valid, frame_abort, busy
    );
endinterface

// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter
//   Arbitrates four frame sources (ARP, ICMP, DHCP, UDP) onto one MAC byte
//   stream. One frame at a time: IDLE -> GRANT (one-cycle tx_enable pulse)
//   -> BUSY (bytes muxed through) -> GAP (inter-frame gap) -> IDLE.
//   A frame watchdog aborts a frame that runs too long and masks that
//   source until its tx_active drops.
//   Parameters:
//     IFG_CYCLES        idle gap between frames in tx_clock cycles (1..2047)
//     MAX_FRAME_CYCLES  watchdog limit per frame in tx_clock cycles (1..2047)
//   Ports:
//     tx_clock  single clock
//     reset     asynchronous active-high reset
//     bus       eth_tx_arbiter_if.master (see interface file for signals)
//   Build option:
//     ETH_TX_ARB_ROUND_ROBIN_EN  defined: round-robin arbitration starting
//                                after the last granted source;
//                                undefined: fixed priority, index 0 highest.
module eth_tx_arbiter #(
    parameter int unsigned IFG_CYCLES       = 12,
    parameter int unsigned MAX_FRAME_CYCLES = 1600
) (
    input logic               tx_clock,
    input logic               reset,
    eth_tx_arbiter_if.master  bus
);

    if (IFG_CYCLES < 1 || IFG_CYCLES > 2047) begin : g_bad_ifg
        $error("eth_tx_arbiter: IFG_CYCLES must be within 1..2047");
    end
    if (MAX_FRAME_CYCLES < 1 || MAX_FRAME_CYCLES > 2047) begin : g_bad_max
        $error("eth_tx_arbiter: MAX_FRAME_CYCLES must be within 1..2047");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_BUSY,
        ST_GAP
    } state_t;

    localparam logic [10:0] GAP_LOAD   = 11'(IFG_CYCLES - 1);
    localparam logic [10:0] FRAME_LAST = 11'(MAX_FRAME_CYCLES - 1);

    state_t      state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic [10:0] frame_cnt_q, frame_cnt_d;
    logic [10:0] gap_cnt_q, gap_cnt_d;
    logic [3:0]  abort_mask_q, abort_mask_d;
    logic [3:0]  grant_q, grant_d;
    logic        frame_abort_q, frame_abort_d;
    logic        busy_q, busy_d;

    logic [3:0]  req_eff;
    logic [1:0]  winner;
    logic        sel_active;

`ifdef ETH_TX_ARB_ROUND_ROBIN_EN
    logic [1:0]  rr_ptr_q, rr_ptr_d;
    logic [1:0]  cand;
`endif

    assign req_eff    = bus.req & ~abort_mask_q;
    assign sel_active = bus.src_active[sel_q];

    // Winner selection: later assignments override earlier ones, so the scan
    // order is arranged with the highest-priority candidate visited last.
    always_comb begin
        winner = 2'd0;
`ifdef ETH_TX_ARB_ROUND_ROBIN_EN
        cand = 2'd0;
        // Visits ptr, ptr+3, ptr+2, ptr+1 (mod 4): ptr+1 ends up preferred.
        for (int unsigned i = 0; i < 4; i++) begin
            cand = rr_ptr_q + 2'(4 - i);
            if (req_eff[cand]) begin
                winner = cand;
            end
        end
`else
        for (int unsigned i = 0; i < 4; i++) begin
            if (req_eff[3 - i]) begin
                winner = 2'(3 - i);
            end
        end
`endif
    end

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        frame_cnt_d   = frame_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        // A masked source is released as soon as its tx_active drops.
        abort_mask_d  = abort_mask_q & bus.src_active;
        grant_d       = '0;
        frame_abort_d = 1'b0;
`ifdef ETH_TX_ARB_ROUND_ROBIN_EN
        rr_ptr_d      = rr_ptr_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (req_eff != '0) begin
                    sel_d   = winner;
                    grant_d = 4'b0001 << winner;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                frame_cnt_d = '0;
                state_d     = ST_BUSY;
`ifdef ETH_TX_ARB_ROUND_ROBIN_EN
                rr_ptr_d    = sel_q;
`endif
            end
            ST_BUSY: begin
                frame_cnt_d = frame_cnt_q + 11'd1;
                // Frame counter is 0 only on the first BUSY cycle, where the
                // source's tx_active still reflects its own tx_enable.
                if (frame_cnt_q != '0 && !sel_active) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = GAP_LOAD;
                end else if (frame_cnt_q == FRAME_LAST) begin
                    frame_abort_d       = 1'b1;
                    abort_mask_d[sel_q] = 1'b1;
                    state_d             = ST_GAP;
                    gap_cnt_d           = GAP_LOAD;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 11'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge tx_clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            sel_q         <= '0;
            frame_cnt_q   <= '0;
            gap_cnt_q     <= '0;
            abort_mask_q  <= '0;
            grant_q       <= '0;
            frame_abort_q <= 1'b0;
            busy_q        <= 1'b0;
`ifdef ETH_TX_ARB_ROUND_ROBIN_EN
            rr_ptr_q      <= '0;
`endif
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            frame_cnt_q   <= frame_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            abort_mask_q  <= abort_mask_d;
            grant_q       <= grant_d;
            frame_abort_q <= frame_abort_d;
            busy_q        <= busy_d;
`ifdef ETH_TX_ARB_ROUND_ROBIN_EN
            rr_ptr_q      <= rr_ptr_d;
`endif
        end
    end

    assign bus.grant       = grant_q;
    assign bus.frame_abort = frame_abort_q;
    assign bus.busy        = busy_q;
    assign bus.tx_valid    = (state_q == ST_BUSY) && sel_active;

    always_comb begin
        bus.tx_data = '0;
        if (state_q == ST_BUSY) begin
            bus.tx_data = bus.src_data[{sel_q, 3'b000} +: 8];
        end
    end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
module tb_eth_tx_arbiter;
    localparam int unsigned IFG  = 12;
    localparam int unsigned MAXF = 1600;

    logic clk = 1'b0;
    logic rst;

    eth_tx_arbiter_if bus_if();

    eth_tx_arbiter #(
        .IFG_CYCLES       (IFG),
        .MAX_FRAME_CYCLES (MAXF)
    ) dut (
        .tx_clock (clk),
        .reset    (rst),
        .bus      (bus_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] exp_grant[$];
    logic [7:0] exp_byte[$];
    int         exp_abort[$];
    int         exp_gap[$];

    bit prev_valid  = 1'b0;
    bit gap_armed   = 1'b0;
    int gap_cnt     = 0;
    int since_grant = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an output event.
    always @(negedge clk) begin
        if (rst) begin
            gap_armed  = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (bus_if.grant != '0) begin
                since_grant = 0;
                check("grant_onehot", int'($countones(bus_if.grant)), 1);
                if (exp_grant.size() == 0)
                    check("grant_unexpected", int'(bus_if.grant), 0);
                else
                    check("grant", int'(bus_if.grant), int'(exp_grant.pop_front()));
            end else begin
                since_grant++;
            end

            if (bus_if.tx_valid) begin
                if (exp_byte.size() == 0)
                    check("tx_valid_unexpected", int'(bus_if.tx_valid), 0);
                else
                    check("tx_data", int'(bus_if.tx_data), int'(exp_byte.pop_front()));
            end else if (!bus_if.busy || bus_if.grant != '0) begin
                check("tx_data_idle", int'(bus_if.tx_data), 0);
            end

            if (bus_if.frame_abort) begin
                if (exp_abort.size() == 0)
                    check("abort_unexpected", int'(bus_if.frame_abort), 0);
                else
                    check("abort_latency", since_grant, exp_abort.pop_front());
            end

            // Gap length: busy cycles counted after the cycle tx_valid fell.
            if (prev_valid && !bus_if.tx_valid && bus_if.busy) begin
                gap_armed = 1'b1;
                gap_cnt   = 0;
            end else if (gap_armed && bus_if.busy) begin
                gap_cnt++;
            end else if (gap_armed && !bus_if.busy) begin
                gap_armed = 1'b0;
                if (exp_gap.size() == 0)
                    check("gap_unexpected", gap_cnt, -1);
                else
                    check("gap_len", gap_cnt, exp_gap.pop_front());
            end
            prev_valid = bus_if.tx_valid;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Call just after a posedge; exp_lat counts clock cycles until grant shows.
    task automatic wait_grant(input int src, input int exp_lat);
        logic [3:0] g;
        int w;
        bit got;
        g = 4'(1 << src);
        exp_grant.push_back(g);
        w = 0;
        got = 1'b0;
        while (!got && w < 200) begin
            @(negedge clk);
            if (bus_if.grant == g) got = 1'b1;
            else w++;
        end
        check("grant_wait", int'(got), 1);
        if (got) check("grant_latency", w, exp_lat);
    endtask

    // Source model: tx_active rises on the first BUSY cycle, nbytes descending
    // from first, then drops.
    task automatic run_frame(input int src, input int nbytes, input logic [7:0] first,
                             input logic [3:0] req_after, input int exp_lat);
        wait_grant(src, exp_lat);
        @(posedge clk); #1;
        bus_if.req = req_after;
        bus_if.src_active[src] = 1'b1;
        for (int k = 0; k < nbytes; k++) begin
            bus_if.src_data[8*src +: 8] = first - 8'(k);
            exp_byte.push_back(first - 8'(k));
            @(posedge clk); #1;
        end
        bus_if.src_active[src] = 1'b0;
        bus_if.src_data[8*src +: 8] = 8'h00;
        exp_gap.push_back(int'(IFG));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1;
        bus_if.req        = '0;
        bus_if.src_active = '0;
        bus_if.src_data   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", int'({bus_if.grant, bus_if.tx_data, bus_if.tx_valid,
                                      bus_if.frame_abort, bus_if.busy}), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // Single ARP frame, 30 bytes 0x1D..0x00, grant one cycle after req.
        bus_if.req = 4'b0001;
        run_frame(0, 30, 8'h1D, 4'b0000, 1);
        idle(20);

        // Watchdog: DHCP source stuck active.
        bus_if.req = 4'b0100;
        wait_grant(2, 1);
        @(posedge clk); #1;
        bus_if.src_active[2] = 1'b1;
        bus_if.src_data[23:16] = 8'hA5;
        repeat (MAXF) exp_byte.push_back(8'hA5);
        exp_abort.push_back(int'(MAXF) + 1);
        exp_gap.push_back(int'(IFG) - 1);
        // req[2] stays high: no regrant may appear while tx_active is stuck.
        idle(int'(MAXF + IFG) + 40);
        bus_if.src_active[2] = 1'b0;
        bus_if.src_data[23:16] = 8'h00;
        run_frame(2, 3, 8'h03, 4'b0000, 2);
        idle(20);

        // Reset asserted on the 10th BUSY cycle of an ARP frame.
        bus_if.req = 4'b0001;
        wait_grant(0, 1);
        @(posedge clk); #1;
        bus_if.req = 4'b0000;
        bus_if.src_active[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus_if.src_data[7:0] = 8'h60 + 8'(k);
            exp_byte.push_back(8'h60 + 8'(k));
            if (k < 9) begin
                @(posedge clk); #1;
            end
        end
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        check("reset_midframe_outputs", int'({bus_if.grant, bus_if.tx_data, bus_if.tx_valid,
                                               bus_if.frame_abort, bus_if.busy}), 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("reset_no_abort", int'(bus_if.frame_abort), 0);
        end
        bus_if.src_active = '0;
        bus_if.src_data   = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        bus_if.req = 4'b0010;
        run_frame(1, 4, 8'h0F, 4'b0000, 1);
        idle(20);

`ifdef ETH_TX_ARB_ROUND_ROBIN_EN
        // Last grant was index 1: 0 wins over pending 1, then 1 follows.
        bus_if.req = 4'b0011;
        run_frame(0, 3, 8'h21, 4'b0010, 1);
        run_frame(1, 3, 8'h31, 4'b0000, 14);
        idle(20);
        bus_if.req = 4'b1000;
        run_frame(3, 2, 8'h41, 4'b0000, 1);
        idle(20);
        // Pointer at 3; all four requesting continuously: 0,1,2,3,0.
        bus_if.req = 4'b1111;
        run_frame(0, 2, 8'h51, 4'b1111, 1);
        run_frame(1, 2, 8'h61, 4'b1111, 14);
        run_frame(2, 2, 8'h71, 4'b1111, 14);
        run_frame(3, 2, 8'h81, 4'b1111, 14);
        run_frame(0, 2, 8'h91, 4'b0000, 14);
        idle(20);
`else
        // Fixed priority: ICMP before UDP, UDP after frame plus gap.
        bus_if.req = 4'b1010;
        run_frame(1, 5, 8'h44, 4'b1000, 1);
        // ARP request pulse that drops during the gap must not be granted.
        idle(3);
        bus_if.req[0] = 1'b1;
        idle(3);
        bus_if.req[0] = 1'b0;
        run_frame(3, 4, 8'h33, 4'b0000, 8);
        idle(20);
`endif

        idle(40);
        check("grant_queue_empty", exp_grant.size(), 0);
        check("byte_queue_empty",  exp_byte.size(),  0);
        check("abort_queue_empty", exp_abort.size(), 0);
        check("gap_queue_empty",   exp_gap.size(),   0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/eth_tx_arbiter.md
ETH_TX_ARBITER -- requirements
Module: eth_tx_arbiter

Interface
REQ-001 SHALL have parameter IFG_CYCLES, default 12, the idle gap in tx_clock cycles enforced between frames.
REQ-002 SHALL have parameter MAX_FRAME_CYCLES, default 1600, the watchdog limit on one frame's duration in tx_clock cycles.
REQ-003 SHALL have port tx_clock, input, 1, the single clock for all logic.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port req, input, 4, the per-source tx_request, index 0 = ARP, 1 = ICMP, 2 = DHCP, 3 = UDP.
REQ-006 SHALL have port src_active, input, 4, the per-source tx_active.
REQ-007 SHALL have port src_data, input, 32, the per-source tx_data, with source n on bits [8n+7:8n].
REQ-008 SHALL have port grant, output, 4, the per-source tx_enable, one-hot one-cycle pulse.
REQ-009 SHALL have port tx_data, output, 8, the muxed byte to the MAC.
REQ-010 SHALL have port tx_valid, output, 1, high while the granted source's src_active is high in BUSY.
REQ-011 SHALL have port frame_abort, output, 1, a one-cycle pulse on watchdog expiry.
REQ-012 SHALL have port busy, output, 1, high in any state except IDLE.

Function
REQ-013 SHALL implement states IDLE, GRANT, BUSY and GAP.
REQ-014 IDLE: if req is nonzero, SHALL latch the winner index into sel and go to GRANT on the next edge.
REQ-015 GRANT: SHALL drive grant[sel]=1 for exactly one cycle, clear the frame counter, and go to BUSY.
REQ-016 BUSY: tx_data SHALL equal src_data[sel] combinationally, tx_valid SHALL equal src_active[sel], and the frame counter SHALL increment every cycle.
REQ-017 BUSY: src_active[sel]=0 SHALL cause a move to GAP and load the gap counter with IFG_CYCLES-1.
REQ-018 Because a source's tx_active includes its own tx_enable, src_active[sel] SHALL be ignored for the first BUSY cycle only.
REQ-019 BUSY: when the frame counter reaches MAX_FRAME_CYCLES-1 with src_active[sel] still high, frame_abort SHALL pulse and the state SHALL move to GAP.
REQ-020 After an abort, sel's request SHALL be masked until src_active[sel] falls.
REQ-021 GAP: the gap counter SHALL decrement to 0 and then return to IDLE, giving an IFG of exactly IFG_CYCLES cycles.
REQ-022 A req from a source that drops before its grant SHALL NOT be granted.
REQ-023 New requests arriving during GRANT, BUSY or GAP SHALL be held pending by the source and arbitrated only in IDLE.
REQ-024 tx_data SHALL be 8'h00 outside BUSY.
REQ-025 grant SHALL never carry more than one set bit.
REQ-026 Counters SHALL be 11 bits wide, and parameters outside 1..2047 SHALL be illegal.

Reset
REQ-027 Reset SHALL asynchronously force the state to IDLE.
REQ-028 Reset SHALL force grant=0, tx_valid=0, frame_abort=0, tx_data=0 and busy=0.
REQ-029 Reset SHALL force sel=0, the round-robin pointer to 0, all counters to 0, and the abort mask to cleared.
REQ-030 Reset during BUSY SHALL terminate the frame with no frame_abort pulse.

Configuration
REQ-031 With ETH_TX_ARB_ROUND_ROBIN_EN defined, the winner SHALL be the first requesting index strictly after the last granted index, wrapping 3->0, with the pointer updated in GRANT.
REQ-032 With ETH_TX_ARB_ROUND_ROBIN_EN undefined, the winner SHALL be fixed priority, lowest index wins, so ARP is highest.

Verification
REQ-033 With req=4'b0001, src_active high for 30 cycles carrying bytes 0x1D..0x00: grant=4'b0001 one cycle after req, tx_data shows the 30 bytes in order, busy falls 12 cycles after src_active falls.
REQ-034 With req=4'b1010 in IDLE and fixed priority: grant=4'b0010 first, then 4'b1000 after that frame plus the 12-cycle gap.
REQ-035 With ETH_TX_ARB_ROUND_ROBIN_EN defined, last grant index 1 and req=4'b0011: grant=4'b0001; with all four requesting continuously, grants rotate 0,1,2,3,0.
REQ-036 With src_active[2] stuck high after grant: frame_abort pulses after 1600 BUSY cycles, followed by GAP then IDLE, and source 2 is not regranted until src_active[2] falls.
REQ-037 Asserting reset mid-BUSY on cycle 10 of a frame: all outputs read 0 immediately, frame_abort stays 0, and a new req is granted normally after reset is released.
